// File: rtl/mcpu_prog_loader_if.sv
// Stream-in and RAM-write signal bundle for the MCPU program loader.
// Handshake: a stream byte transfers on a rising clk edge where s_valid && s_ready
// are both high; the source holds s_data and s_valid stable until that edge, and
// the loader may drop s_ready whenever it cannot take a byte.
interface mcpu_prog_loader_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) ();
  logic [7:0]           s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_wdata;

  // Loader side: consumes the stream, drives the RAM write port.
  modport slave (
    input  s_data, s_valid,
    output s_ready, ram_we, ram_addr, ram_wdata
  );

  // System side: stream source and RAM.
  modport master (
    output s_data, s_valid,
    input  s_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mcpu_prog_loader.sv
// Boot loader for the MCPU: receives header / words / checksum over a byte
// stream, writes the words into RAM from address 0, zero-fills the rest and
// releases the CPU reset only once the image has been verified.
module mcpu_prog_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  mcpu_prog_loader_if.slave   bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [3:0]          dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HI, S_LO, S_WRITE, S_CSUM, S_FILL, S_RUN, S_ERROR
  } state_t;

  typedef struct packed {
    logic s_ready;
    logic busy;
    logic done;
    logic error;
    logic cpu_reset;
  } flags_t;

  // Moore flag set belonging to each state; loaded together with the state so
  // the flags are registers that always match the current state.
  function automatic flags_t flags_of(state_t s);
    flags_t f;
    f.s_ready   = (s == S_HDR) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
    f.busy      = (s == S_HDR) || (s == S_HI) || (s == S_LO) ||
                  (s == S_WRITE) || (s == S_CSUM) || (s == S_FILL);
    f.done      = (s == S_RUN);
    f.error     = (s == S_ERROR);
    f.cpu_reset = (s != S_RUN);
    return f;
  endfunction

  state_t               state;
  flags_t               flags;
  logic [7:0]           csum;
  logic [7:0]           hi;
  logic [ADDR_SIZE-1:0] addr;
  logic [ADDR_SIZE:0]   remaining;
  logic                 ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_wdata;

  wire xfer = bus.s_valid && flags.s_ready;

  assign bus.s_ready   = flags.s_ready;
  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign cpu_reset     = flags.cpu_reset;
  assign busy          = flags.busy;
  assign done          = flags.done;
  assign error         = flags.error;
  assign dbg_state     = state;

  // Load FSM with registered flags and RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      flags     <= flags_of(S_IDLE);
      csum      <= '0;
      hi        <= '0;
      addr      <= '0;
      remaining <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state <= S_HDR;
            flags <= flags_of(S_HDR);
          end
        end
        S_HDR: begin
          if (xfer) begin
            remaining <= (bus.s_data == 8'd0) ? (ADDR_SIZE+1)'(RAM_SIZE)
                                              : (ADDR_SIZE+1)'(bus.s_data);
            csum      <= bus.s_data;
            addr      <= '0;
            state     <= S_HI;
            flags     <= flags_of(S_HI);
          end
        end
        S_HI: begin
          if (xfer) begin
            hi    <= bus.s_data;
            csum  <= csum ^ bus.s_data;
            state <= S_LO;
            flags <= flags_of(S_LO);
          end
        end
        S_LO: begin
          if (xfer) begin
            csum      <= csum ^ bus.s_data;
            ram_we    <= 1'b1;
            ram_addr  <= addr;
            ram_wdata <= WORD_SIZE'({hi, bus.s_data});
            state     <= S_WRITE;
            flags     <= flags_of(S_WRITE);
          end
        end
        S_WRITE: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == (ADDR_SIZE+1)'(1)) begin
            state <= S_CSUM;
            flags <= flags_of(S_CSUM);
          end else begin
            state <= S_HI;
            flags <= flags_of(S_HI);
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (bus.s_data != csum) begin
              state <= S_ERROR;
              flags <= flags_of(S_ERROR);
            end else if (addr == '0) begin
              // addr has wrapped to 0 only after a full RAM_SIZE-word image.
              state <= S_RUN;
              flags <= flags_of(S_RUN);
            end else begin
              ram_we    <= 1'b1;
              ram_addr  <= addr;
              ram_wdata <= '0;
              state     <= S_FILL;
              flags     <= flags_of(S_FILL);
            end
          end
        end
        S_FILL: begin
          if (ram_addr == ADDR_SIZE'(RAM_SIZE - 1)) begin
            state <= S_RUN;
            flags <= flags_of(S_RUN);
          end else begin
            ram_we    <= 1'b1;
            ram_addr  <= ram_addr + 1'b1;
            ram_wdata <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          flags <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: doc/mcpu_prog_loader.md
# mcpu_prog_loader

Program loader sitting directly upstream of the MCPU core and its instruction/data RAM. It accepts a byte stream (header, instruction words, checksum) over a valid/ready handshake and writes the words into RAM from address 0. It zero-fills the unused RAM and holds the CPU in reset until the image has been fully and correctly loaded. It replaces hierarchical memory preloading with a synthesizable boot path.

## Interface
Parameters:
- WORD_SIZE, 16, instruction width: 4-bit opcode plus three 4-bit operand fields.
- ADDR_SIZE, 8, RAM address width.
- RAM_SIZE, 256, number of RAM words; must equal 2^ADDR_SIZE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, RUN or ERROR.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte; a byte transfers on a rising edge with s_valid && s_ready.
- ram_we  out  1  RAM write strobe, one cycle per word.
- ram_addr  out  ADDR_SIZE  RAM write address.
- ram_wdata  out  WORD_SIZE  RAM write data.
- cpu_reset  out  1  active-high reset to MCPU; 1 except in RUN.
- busy  out  1  high in HDR, HI, LO, WRITE, CSUM and FILL.
- done  out  1  high in RUN.
- error  out  1  high in ERROR.

## Operation
- Stream format: header byte H, then word count N = (H==0) ? 256 : H, then N words (high byte first), then checksum byte C.
- C must equal the XOR of H and all 2N payload bytes.
- States: IDLE, HDR, HI, LO, WRITE, CSUM, FILL, RUN, ERROR. Outputs are Moore, decoded from state and registers.
- IDLE: s_ready=0. start goes to HDR.
- HDR: s_ready=1. On accept, latch N into a 9-bit counter, set csum=H, clear addr to 0, go to HI.
- HI: s_ready=1. On accept, latch hi byte, csum ^= byte, go to LO.
- LO: s_ready=1. On accept, latch lo byte, csum ^= byte, go to WRITE.
- WRITE: s_ready=0, ram_we=1, ram_wdata={hi,lo}, ram_addr=addr. Then addr++ and remaining--. If remaining reaches 0, go to CSUM; otherwise go to HI.
- CSUM: s_ready=1. On accept: if byte==csum, go to FILL (N<256) or RUN (N==256); otherwise go to ERROR.
- FILL: ram_we=1, ram_wdata=0, one address per cycle from N through RAM_SIZE-1. After writing address RAM_SIZE-1, go to RUN. No stream bytes are accepted during FILL.
- RUN: cpu_reset=0, done=1. start goes to HDR, and cpu_reset is reasserted in that HDR cycle.
- ERROR: error=1, cpu_reset=1, s_ready=0. No fill is performed. start goes to HDR.
- start is ignored in HDR through FILL.
- addr is ADDR_SIZE bits. With N=256 the last write is to address 255, and the increment wrap to 0 is never used for a write.
- The remaining-word counter is 9 bits so that N=256 fits.

## Timing
- Reset values: state=IDLE, s_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_reset=1, busy=0, done=0, error=0, csum=0.
- Reset takes effect immediately (asynchronously) from any state, including mid-write.
- Each word takes at least 3 cycles (HI accept, LO accept, WRITE).
- Minimum total load time, from the start edge to the first RUN cycle, is 1 + 1 + 3N + 1 + (256−N) cycles: start→HDR, header accept, words, checksum accept, fill.
- With continuous s_valid: byte accepts occur on consecutive cycles except for the WRITE bubble.
- s_valid low in an accepting state stalls indefinitely with no state change.
- The stream source may change s_data only after a transfer.
- ram_we is never asserted outside WRITE and FILL.

## Test plan
- 16-word program: H=0x10, words 0x0001..0x0010, correct C. Required: mem[0..15]=0x0001..0x0010, mem[16..255]=0, exactly 256 ram_we pulses, done=1 and cpu_reset=0 after 291 cycles from the start edge.
- H=0x00 with 256 words where word i=i, correct C. Required: no FILL cycles, last write addr=255 data=0x00FF, address 0 never rewritten, done=1.
- 4-word image with C off by 0x01. Required: error=1, cpu_reset=1, no writes after the 4 words, done=0. A later start plus a correct stream must give done=1 and error=0.
- 8-word image with s_valid deasserted 0–5 random cycles between bytes. Required: same RAM contents and checksum result as the gap-free load; no transfer when s_valid=0.
- reset=0 asserted during the LO state of word 5. Required: ram_we=0, cpu_reset=1, s_ready=0 in the same cycle and state IDLE. A full reload afterwards must succeed.
- start pulsed in RUN. Required: cpu_reset=1 and s_ready=1 on the next cycle (HDR), and the new image overwrites RAM.
